rs_station: RTL and testbench

Parametrised reservation station for the out-of-order RISC-V core: it buffers up to DEPTH issued instructions and tracks operand tags against CDB_N common-data-bus broadcasts. It dispatches the oldest ready entry to its functional unit over a valid/ready handshake. It sits between the issue/rename stage and one functional unit (ALU, branch, or address-generation instance). It generalises the fixed 7-slot station with channel-count, depth and width parameters, same-cycle CDB bypass, age-ordered selection, a backpressured dispatch port and flush.

---
 rtl/rs_pkg.sv | 26 ++
 rtl/rs_station_age_matrix.sv | 42 ++++
 rtl/rs_station.sv | 187 ++++++++++++++++++
 tb/tb_rs_station.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: tag-zero encoding, op-bundle layout, CDB slice helper.
// Pure constants/functions; no state, no latency.
package rs_pkg;

  localparam int TAG_ZERO = 0;

  // Op bundle is {fun7, fun3, opcode}, LSB first.
  localparam int OPC_LSB     = 0;
  localparam int OPC_W       = 7;
  localparam int F3_LSB      = OPC_LSB + OPC_W;
  localparam int F3_W        = 3;
  localparam int F7_LSB      = F3_LSB + F3_W;
  localparam int F7_W        = 7;
  localparam int OP_BUNDLE_W = F7_LSB + F7_W;

  localparam int SLICE_MAX_VEC = 2048;
  localparam int SLICE_MAX_W   = 64;

  // Field 'bus' of width w from a packed per-bus vector (bus 0 in LSBs); caller truncates.
  function automatic logic [SLICE_MAX_W-1:0] cdb_slice(input logic [SLICE_MAX_VEC-1:0] vec,
                                                       input int unsigned bus,
                                                       input int unsigned w);
    return SLICE_MAX_W'(vec >> (bus * w));
  endfunction

endpackage

// File: rtl/rs_station_age_matrix.sv
// Issue-order age matrix: one-hot grant of the oldest ready entry, combinational from registered age.
// Row i holds the entries older than i; set at allocation, column cleared when a slot is reused.
module age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  always_comb begin
    occ_d = (occ_q & ~free_i) | alloc_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_i[i]) age_d[i] = occ_q & ~free_i;
      else            age_d[i] = age_q[i] & ~alloc_i;
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++)
      grant_o[i] = ready_i[i] && ((age_q[i] & ready_i) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: rtl/rs_station.sv
// Reservation station: buffers issued ops, snoops CDB tags, presents the oldest ready entry (1-cycle issue-to-dispatch).
// Presented entry is locked until disp_ready; issue_ready drops when full and depends only on the registered count.
module rs_station
  import rs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int OP_W  = OP_BUNDLE_W,
  parameter int CDB_N = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [OP_W-1:0]            issue_op,
  input  logic [TAG_W-1:0]           issue_dest,
  input  logic [TAG_W-1:0]           issue_qj,
  input  logic [TAG_W-1:0]           issue_qk,
  input  logic [XLEN-1:0]            issue_vj,
  input  logic [XLEN-1:0]            issue_vk,
  input  logic [XLEN-1:0]            issue_imm,
  input  logic [CDB_N-1:0]           cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]     cdb_tag,
  input  logic [CDB_N*XLEN-1:0]      cdb_data,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [OP_W-1:0]            disp_op,
  output logic [TAG_W-1:0]           disp_dest,
  output logic [XLEN-1:0]            disp_vj,
  output logic [XLEN-1:0]            disp_vk,
  output logic [XLEN-1:0]            disp_imm,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [TAG_W-1:0] TZ      = TAG_W'(TAG_ZERO);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [OP_W-1:0]  op_q   [DEPTH];
  logic [OP_W-1:0]  op_d   [DEPTH];
  logic [TAG_W-1:0] dest_q [DEPTH];
  logic [TAG_W-1:0] dest_d [DEPTH];
  logic [TAG_W-1:0] qj_q   [DEPTH];
  logic [TAG_W-1:0] qj_d   [DEPTH];
  logic [TAG_W-1:0] qk_q   [DEPTH];
  logic [TAG_W-1:0] qk_d   [DEPTH];
  logic [XLEN-1:0]  vj_q   [DEPTH];
  logic [XLEN-1:0]  vj_d   [DEPTH];
  logic [XLEN-1:0]  vk_q   [DEPTH];
  logic [XLEN-1:0]  vk_d   [DEPTH];
  logic [XLEN-1:0]  imm_q  [DEPTH];
  logic [XLEN-1:0]  imm_d  [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic             lock_q, lock_d;
  logic [IW-1:0]    lock_idx_q, lock_idx_d;
  logic [OP_W-1:0]  last_op_q;
  logic [TAG_W-1:0] last_dest_q;
  logic [XLEN-1:0]  last_vj_q, last_vk_q, last_imm_q;

  logic [TAG_W-1:0] bus_tag  [CDB_N];
  logic [XLEN-1:0]  bus_data [CDB_N];
  logic [DEPTH-1:0] ready_vec, grant, alloc_vec, free_vec;
  logic [IW-1:0]    free_idx, sel_idx, grant_idx;
  logic             do_issue, do_disp;

  // Lowest bus index wins on duplicate tags; tag zero never matches.
  function automatic logic [TAG_W+XLEN-1:0] snoop(input logic [TAG_W-1:0] q, input logic [XLEN-1:0] v);
    logic [TAG_W+XLEN-1:0] r;
    r = {q, v};
    for (int b = CDB_N-1; b >= 0; b--)
      if (q != TZ && cdb_valid[b] && bus_tag[b] == q) r = {TZ, bus_data[b]};
    return r;
  endfunction

  always_comb begin
    for (int b = 0; b < CDB_N; b++) begin
      bus_tag[b]  = TAG_W'(cdb_slice(SLICE_MAX_VEC'(cdb_tag), b, TAG_W));
      bus_data[b] = XLEN'(cdb_slice(SLICE_MAX_VEC'(cdb_data), b, XLEN));
    end
    free_idx  = '0;
    ready_vec = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = IW'(i);
      ready_vec[i] = vld_q[i] && (qj_q[i] == TZ) && (qk_q[i] == TZ);
    end
  end

  age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .alloc_i (alloc_vec),
    .free_i  (free_vec),
    .ready_i (ready_vec),
    .grant_o (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) grant_idx = IW'(i);
    sel_idx    = lock_q ? lock_idx_q : grant_idx;
    disp_valid = lock_q || (ready_vec != '0);
    do_disp    = disp_valid && disp_ready;
    do_issue   = issue_valid && issue_ready && !flush;
    alloc_vec  = do_issue ? (DEPTH'(1) << free_idx) : '0;
    free_vec   = flush ? '1 : (do_disp ? (DEPTH'(1) << sel_idx) : '0);
  end

  assign issue_ready = (count_q < DEPTH_C);
  assign count       = count_q;
  assign disp_op     = disp_valid ? op_q[sel_idx]   : last_op_q;
  assign disp_dest   = disp_valid ? dest_q[sel_idx] : last_dest_q;
  assign disp_vj     = disp_valid ? vj_q[sel_idx]   : last_vj_q;
  assign disp_vk     = disp_valid ? vk_q[sel_idx]   : last_vk_q;
  assign disp_imm    = disp_valid ? imm_q[sel_idx]  : last_imm_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]   = op_q[i];
      dest_d[i] = dest_q[i];
      imm_d[i]  = imm_q[i];
      {qj_d[i], vj_d[i]} = snoop(qj_q[i], vj_q[i]);
      {qk_d[i], vk_d[i]} = snoop(qk_q[i], vk_q[i]);
      if (alloc_vec[i]) begin
        op_d[i]   = issue_op;
        dest_d[i] = issue_dest;
        imm_d[i]  = issue_imm;
        {qj_d[i], vj_d[i]} = snoop(issue_qj, issue_vj);
        {qk_d[i], vk_d[i]} = snoop(issue_qk, issue_vk);
      end
    end
    vld_d      = flush ? '0 : ((vld_q & ~free_vec) | alloc_vec);
    count_d    = flush ? '0 : (count_q + CW'(do_issue) - CW'(do_disp));
    lock_d     = !flush && disp_valid && !disp_ready;
    lock_idx_d = disp_valid ? sel_idx : lock_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      count_q     <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      last_op_q   <= '0;
      last_dest_q <= '0;
      last_vj_q   <= '0;
      last_vk_q   <= '0;
      last_imm_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        imm_q[i]  <= '0;
      end
    end else begin
      vld_q      <= vld_d;
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      if (disp_valid) begin
        last_op_q   <= disp_op;
        last_dest_q <= disp_dest;
        last_vj_q   <= disp_vj;
        last_vk_q   <= disp_vk;
        last_imm_q  <= disp_imm;
      end
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= op_d[i];
        dest_q[i] <= dest_d[i];
        qj_q[i]   <= qj_d[i];
        qk_q[i]   <= qk_d[i];
        vj_q[i]   <= vj_d[i];
        vk_q[i]   <= vk_d[i];
        imm_q[i]  <= imm_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: per-cycle vector table plus hand sequences for full, flush and reset.
module tb_rs_station;

  logic        clk, rst_n, flush;
  logic        issue_valid, issue_ready;
  logic [16:0] issue_op;
  logic [4:0]  issue_dest, issue_qj, issue_qk;
  logic [31:0] issue_vj, issue_vk, issue_imm;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        disp_valid, disp_ready;
  logic [16:0] disp_op;
  logic [4:0]  disp_dest;
  logic [31:0] disp_vj, disp_vk, disp_imm;
  logic [3:0]  count;

  int checks = 0;
  int failures = 0;

  rs_station dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_dest(issue_dest), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_imm(issue_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_dest(disp_dest), .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_imm(disp_imm),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int iv, dest, qj, vj, qk, vk;
    int c0v, t0, d0, c1v, t1, d1;
    int drdy;
    int edv, edest, evj, evk, ecnt;
  } vec_t;

  vec_t vecs [36];

  function automatic vec_t mk(int iv, int dest, int qj, int vj, int qk, int vk,
                              int c0v, int t0, int d0, int c1v, int t1, int d1, int drdy,
                              int edv, int edest, int evj, int evk, int ecnt);
    vec_t r;
    r.iv = iv; r.dest = dest; r.qj = qj; r.vj = vj; r.qk = qk; r.vk = vk;
    r.c0v = c0v; r.t0 = t0; r.d0 = d0; r.c1v = c1v; r.t1 = t1; r.d1 = d1;
    r.drdy = drdy; r.edv = edv; r.edest = edest; r.evj = evj; r.evk = evk; r.ecnt = ecnt;
    return r;
  endfunction

  function automatic logic [16:0] op_of(int d);
    return {12'hABC, 5'(d)};
  endfunction

  function automatic logic [31:0] imm_of(int d);
    return 32'(d) ^ 32'h0000F0F0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    flush       = 1'b0;
    issue_valid = 1'(v.iv);
    issue_dest  = 5'(v.dest);
    issue_op    = op_of(v.dest);
    issue_imm   = imm_of(v.dest);
    issue_qj    = 5'(v.qj);
    issue_qk    = 5'(v.qk);
    issue_vj    = 32'(v.vj);
    issue_vk    = 32'(v.vk);
    cdb_valid   = {1'(v.c1v), 1'(v.c0v)};
    cdb_tag     = {5'(v.t1), 5'(v.t0)};
    cdb_data    = {32'(v.d1), 32'(v.d0)};
    disp_ready  = 1'(v.drdy);
  endtask

  task automatic set_issue(input int iv, input int dest, input int vj, input int vk, input int drdy);
    drive(mk(iv, dest, 0, vj, 0, vk, 0, 0, 0, 0, 0, 0, drdy, 0, 0, 0, 0, 0));
  endtask

  initial begin
    vecs[0]  = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 0,  0, 0,    0,    0);
    vecs[1]  = mk(1,  3, 0, 5,    0, 7,    0, 0, 0,    0, 0, 0,    1, 0,  0, 0,    0,    0);
    vecs[2]  = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 1,  3, 5,    7,    1);
    vecs[3]  = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 0,  0, 0,    0,    0);
    vecs[4]  = mk(1,  8, 4, 0,    0, 1,    0, 0, 0,    0, 0, 0,    1, 0,  0, 0,    0,    0);
    vecs[5]  = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 0,  0, 0,    0,    1);
    vecs[6]  = mk(0,  0, 0, 0,    0, 0,    1, 4, 'h10, 0, 0, 0,    1, 0,  0, 0,    0,    1);
    vecs[7]  = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 1,  8, 'h10, 1,    1);
    vecs[8]  = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 0,  0, 0,    0,    0);
    vecs[9]  = mk(1,  9, 0, 2,    6, 0,    1, 5, 'h55, 1, 6, 'hAB, 1, 0,  0, 0,    0,    0);
    vecs[10] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 1,  9, 2,    'hAB, 1);
    vecs[11] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 0,  0, 0,    0,    0);
    vecs[12] = mk(1, 10, 7, 0,    0, 3,    0, 0, 0,    0, 0, 0,    1, 0,  0, 0,    0,    0);
    vecs[13] = mk(0,  0, 0, 0,    0, 0,    1, 7, 'h11, 1, 7, 'h22, 1, 0,  0, 0,    0,    1);
    vecs[14] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 1, 10, 'h11, 3,    1);
    vecs[15] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 0,  0, 0,    0,    0);
    vecs[16] = mk(1, 11, 0, 'h44, 0, 'h45, 1, 0, 'h99, 0, 0, 0,    0, 0,  0, 0,    0,    0);
    vecs[17] = mk(0,  0, 0, 0,    0, 0,    1, 0, 'h99, 0, 0, 0,    0, 1, 11, 'h44, 'h45, 1);
    vecs[18] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 1, 11, 'h44, 'h45, 1);
    vecs[19] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    0, 0,  0, 0,    0,    0);
    vecs[20] = mk(1, 12, 2, 0,    0, 'h0A, 0, 0, 0,    0, 0, 0,    0, 0,  0, 0,    0,    0);
    vecs[21] = mk(1, 13, 0, 'h0B, 0, 'h0C, 0, 0, 0,    0, 0, 0,    0, 0,  0, 0,    0,    1);
    vecs[22] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    0, 1, 13, 'h0B, 'h0C, 2);
    vecs[23] = mk(0,  0, 0, 0,    0, 0,    1, 2, 'h20, 0, 0, 0,    0, 1, 13, 'h0B, 'h0C, 2);
    vecs[24] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    0, 1, 13, 'h0B, 'h0C, 2);
    vecs[25] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 1, 13, 'h0B, 'h0C, 2);
    vecs[26] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 1, 12, 'h20, 'h0A, 1);
    vecs[27] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    0, 0,  0, 0,    0,    0);
    vecs[28] = mk(1, 14, 0, 1,    0, 2,    0, 0, 0,    0, 0, 0,    0, 0,  0, 0,    0,    0);
    vecs[29] = mk(1, 15, 4, 0,    0, 0,    0, 0, 0,    0, 0, 0,    0, 1, 14, 1,    2,    1);
    vecs[30] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 1, 14, 1,    2,    2);
    vecs[31] = mk(1, 16, 4, 0,    0, 6,    0, 0, 0,    0, 0, 0,    1, 0,  0, 0,    0,    1);
    vecs[32] = mk(0,  0, 0, 0,    0, 0,    1, 4, 'h44, 0, 0, 0,    1, 0,  0, 0,    0,    2);
    vecs[33] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 1, 15, 'h44, 0,    2);
    vecs[34] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    1, 1, 16, 'h44, 6,    1);
    vecs[35] = mk(0,  0, 0, 0,    0, 0,    0, 0, 0,    0, 0, 0,    0, 0,  0, 0,    0,    0);

    rst_n = 1'b0;
    drive(vecs[0]);
    #3;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_disp_valid",  32'(disp_valid),  32'd0);
    chk("rst_count",       32'(count),       32'd0);
    chk("rst_disp_op",     32'(disp_op),     32'd0);
    chk("rst_disp_dest",   32'(disp_dest),   32'd0);
    chk("rst_disp_vj",     disp_vj,          32'd0);
    chk("rst_disp_vk",     disp_vk,          32'd0);
    chk("rst_disp_imm",    disp_imm,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_issue_ready", i), 32'(issue_ready), 32'd1);
      chk($sformatf("v%0d_disp_valid", i),  32'(disp_valid),  32'(vecs[i].edv));
      chk($sformatf("v%0d_count", i),       32'(count),       32'(vecs[i].ecnt));
      if (vecs[i].edv != 0) begin
        chk($sformatf("v%0d_disp_dest", i), 32'(disp_dest), 32'(vecs[i].edest));
        chk($sformatf("v%0d_disp_vj", i),   disp_vj,         32'(vecs[i].evj));
        chk($sformatf("v%0d_disp_vk", i),   disp_vk,         32'(vecs[i].evk));
        chk($sformatf("v%0d_disp_op", i),   32'(disp_op),    32'(op_of(vecs[i].edest)));
        chk($sformatf("v%0d_disp_imm", i),  disp_imm,        imm_of(vecs[i].edest));
      end
    end

    // Fill all eight slots with dispatch stalled.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      set_issue(1, k, k * 16, k, 0);
      #1;
      chk($sformatf("fill%0d_issue_ready", k), 32'(issue_ready), 32'd1);
      chk($sformatf("fill%0d_count", k),       32'(count),       32'(k - 1));
    end
    @(negedge clk);
    set_issue(1, 31, 1, 1, 0);
    #1;
    chk("full_issue_ready", 32'(issue_ready), 32'd0);
    chk("full_count",       32'(count),       32'd8);
    chk("full_disp_dest",   32'(disp_dest),   32'd1);
    @(negedge clk);
    set_issue(0, 0, 0, 0, 1);
    #1;
    chk("full_ignored_count", 32'(count),     32'd8);
    chk("full_hs_dest",       32'(disp_dest), 32'd1);
    chk("full_hs_vj",         disp_vj,        32'd16);
    @(negedge clk);
    set_issue(0, 0, 0, 0, 0);
    #1;
    chk("freed_issue_ready", 32'(issue_ready), 32'd1);
    chk("freed_count",       32'(count),       32'd7);
    chk("freed_next_dest",   32'(disp_dest),   32'd2);
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      set_issue(0, 0, 0, 0, 1);
      #1;
      chk($sformatf("drain%0d_dest", k), 32'(disp_dest), 32'(k));
    end
    @(negedge clk);
    set_issue(0, 0, 0, 0, 0);
    #1;
    chk("pre_flush_count", 32'(count),     32'd5);
    chk("pre_flush_dest",  32'(disp_dest), 32'd4);

    @(negedge clk);
    set_issue(1, 30, 3, 3, 0);
    flush = 1'b1;
    #1;
    @(negedge clk);
    set_issue(0, 0, 0, 0, 0);
    #1;
    chk("flush_count",       32'(count),       32'd0);
    chk("flush_disp_valid",  32'(disp_valid),  32'd0);
    chk("flush_issue_ready", 32'(issue_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("flush_dropped_valid", 32'(disp_valid), 32'd0);
    chk("flush_dropped_count", 32'(count),      32'd0);

    @(negedge clk);
    set_issue(1, 20, 1, 1, 0);
    @(negedge clk);
    set_issue(1, 21, 2, 2, 0);
    @(negedge clk);
    set_issue(0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_count", 32'(count),      32'd2);
    chk("pre_rst_valid", 32'(disp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_count",       32'(count),       32'd0);
    chk("midrst_disp_valid",  32'(disp_valid),  32'd0);
    chk("midrst_issue_ready", 32'(issue_ready), 32'd1);
    chk("midrst_disp_dest",   32'(disp_dest),   32'd0);
    chk("midrst_disp_vj",     disp_vj,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_issue(1, 5, 9, 9, 1);
    @(negedge clk);
    set_issue(0, 0, 0, 0, 1);
    #1;
    chk("post_rst_valid", 32'(disp_valid), 32'd1);
    chk("post_rst_dest",  32'(disp_dest),  32'd5);
    chk("post_rst_vj",    disp_vj,         32'd9);
    @(negedge clk);
    #1;
    chk("post_rst_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
